// File: rtl/data_buffer_ctrl_pkg.sv
// Shared types and constants for the endpoint data buffer controller.
package data_buffer_ctrl_pkg;

    localparam int BUF_DEPTH = 64;

    // AHB access size encoding used on store_tx_data / get_rx_data
    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_1    = 2'b01,
        SZ_2    = 2'b10,
        SZ_4    = 2'b11
    } size_t;

    // Which side currently owns the buffer contents
    typedef enum logic [1:0] {
        IDLE_BUF = 2'b00,
        TX_FILL  = 2'b01,
        RX_FILL  = 2'b10
    } buf_mode_t;

    // Number of bytes moved by an AHB access of the given size
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (size_t'(sz))
            SZ_1:    size_bytes = 3'd1;
            SZ_2:    size_bytes = 3'd2;
            SZ_4:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_buffer_ctrl_buffer_ram.sv
// Byte-wide circular storage with a 1..4 byte write port and a 1..4 byte read
// port. The single read port lands either in the AHB word register or the USB
// byte register so each side keeps its last result until it reads again.
module buffer_ram
    import data_buffer_ctrl_pkg::*;
#(
    parameter  int DEPTH = BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [2:0]       wr_len,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic             rd_to_usb,
    input  logic [PTR_W-1:0] rd_addr,
    input  logic [2:0]       rd_len,
    output logic [31:0]      word_q,
    output logic [7:0]       byte_q
);

    logic [7:0] mem [DEPTH];

    // Write up to four consecutive bytes; address arithmetic wraps naturally at DEPTH
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < wr_len) begin
                    mem[wr_addr + PTR_W'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read into the destination register; lanes beyond rd_len are forced to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            byte_q <= '0;
        end else if (rd_en) begin
            if (rd_to_usb) begin
                byte_q <= (rd_len != 3'd0) ? mem[rd_addr] : 8'h00;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    word_q[8*i +: 8] <= (3'(i) < rd_len) ? mem[rd_addr + PTR_W'(i)] : 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/data_buffer_ctrl.sv
// Endpoint data buffer controller: arbitrates the AHB word side against the
// USB byte engines, tracks occupancy and enforces one fill direction at a time.
module data_buffer_ctrl
    import data_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  store_tx_data,
    input  logic [31:0] tx_data,
    input  logic [1:0]  get_rx_data,
    output logic [31:0] rx_data,
    input  logic        clear_data_buffer,
    output logic        ahb_stall,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_byte_req,
    output logic [7:0]  tx_byte,
    output logic [7:0]  buffer_occupancy,
    output logic        overflow,
    output logic        underflow,
    output logic        dir_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next, space;
    buf_mode_t        mode, mode_next;

    logic             wr_en, rd_en, rd_to_usb;
    logic [2:0]       wr_len, rd_len;
    logic [31:0]      wr_data;
    logic [2:0]       ahb_wr_n, ahb_rd_n;
    logic             ahb_wr_acc, rx_acc;
    logic             ovf_nxt, udf_nxt, dir_nxt, stall;

    assign ahb_wr_n = size_bytes(store_tx_data);
    assign ahb_rd_n = size_bytes(get_rx_data);
    // Space check deliberately ignores any read completing in the same cycle
    assign space    = DEPTH_C - count;

    // Port arbitration, acceptance decisions and error pulse causes
    always_comb begin
        wr_en      = 1'b0;
        wr_len     = 3'd0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_to_usb  = 1'b0;
        rd_len     = 3'd0;
        ahb_wr_acc = 1'b0;
        rx_acc     = 1'b0;
        ovf_nxt    = 1'b0;
        udf_nxt    = 1'b0;
        dir_nxt    = 1'b0;
        stall      = 1'b0;
        count_next = count;
        if (clear_data_buffer) begin
            count_next = '0;
        end else begin
            // Write port: USB RX wins over AHB store
            if (rx_byte_valid) begin
                if (store_tx_data != SZ_NONE) begin
                    stall = 1'b1;
                end
                if (mode == TX_FILL) begin
                    dir_nxt = 1'b1;
                end else if (count == DEPTH_C) begin
                    ovf_nxt = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_len  = 3'd1;
                    wr_data = {24'h0, rx_byte};
                    rx_acc  = 1'b1;
                end
            end else if (store_tx_data != SZ_NONE) begin
                if (mode == RX_FILL) begin
                    dir_nxt = 1'b1;
                end else if ((PTR_W+1)'(ahb_wr_n) > space) begin
                    ovf_nxt = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    wr_len     = ahb_wr_n;
                    wr_data    = tx_data;
                    ahb_wr_acc = 1'b1;
                end
            end
            // Read port: USB TX wins over AHB get; short reads return what is there
            if (tx_byte_req) begin
                if (get_rx_data != SZ_NONE) begin
                    stall = 1'b1;
                end
                rd_en     = 1'b1;
                rd_to_usb = 1'b1;
                if (count == '0) begin
                    udf_nxt = 1'b1;
                end else begin
                    rd_len = 3'd1;
                end
            end else if (get_rx_data != SZ_NONE) begin
                rd_en = 1'b1;
                if (count < (PTR_W+1)'(ahb_rd_n)) begin
                    udf_nxt = 1'b1;
                    rd_len  = count[2:0];
                end else begin
                    rd_len = ahb_rd_n;
                end
            end
            count_next = count + (PTR_W+1)'(wr_len) - (PTR_W+1)'(rd_len);
        end
    end

    // Direction ownership: first accepted writer claims the buffer until it drains
    always_comb begin
        mode_next = mode;
        if (clear_data_buffer) begin
            mode_next = IDLE_BUF;
        end else begin
            if (mode == IDLE_BUF) begin
                if (ahb_wr_acc) begin
                    mode_next = TX_FILL;
                end else if (rx_acc) begin
                    mode_next = RX_FILL;
                end
            end
            if (count_next == '0) begin
                mode_next = IDLE_BUF;
            end
        end
    end

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= IDLE_BUF;
        end else begin
            mode <= mode_next;
        end
    end

    // Pointers, occupancy and registered error pulses
    always_ff @(posedge clk) begin
        if (rst || clear_data_buffer) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dir_error <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(wr_len);
            rd_ptr    <= rd_ptr + PTR_W'(rd_len);
            count     <= count_next;
            overflow  <= ovf_nxt;
            underflow <= udf_nxt;
            dir_error <= dir_nxt;
        end
    end

    buffer_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_ptr),
        .wr_len    (wr_len),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_to_usb (rd_to_usb),
        .rd_addr   (rd_ptr),
        .rd_len    (rd_len),
        .word_q    (rx_data),
        .byte_q    (tx_byte)
    );

    assign ahb_stall        = stall;
    assign buffer_occupancy = 8'(count);

endmodule

// File: tb/tb_data_buffer_ctrl.sv
// Directed self-checking bench for data_buffer_ctrl.
module tb_data_buffer_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  store_tx_data;
    logic [31:0] tx_data;
    logic [1:0]  get_rx_data;
    logic [31:0] rx_data;
    logic        clear_data_buffer;
    logic        ahb_stall;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        tx_byte_req;
    logic [7:0]  tx_byte;
    logic [7:0]  buffer_occupancy;
    logic        overflow;
    logic        underflow;
    logic        dir_error;

    int checks   = 0;
    int failures = 0;

    data_buffer_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .store_tx_data     (store_tx_data),
        .tx_data           (tx_data),
        .get_rx_data       (get_rx_data),
        .rx_data           (rx_data),
        .clear_data_buffer (clear_data_buffer),
        .ahb_stall         (ahb_stall),
        .rx_byte_valid     (rx_byte_valid),
        .rx_byte           (rx_byte),
        .tx_byte_req       (tx_byte_req),
        .tx_byte           (tx_byte),
        .buffer_occupancy  (buffer_occupancy),
        .overflow          (overflow),
        .underflow         (underflow),
        .dir_error         (dir_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill62();
        for (int k = 0; k < 15; k++) begin
            store_tx_data = 2'b11;
            tx_data = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            tick();
        end
        store_tx_data = 2'b10;
        tx_data = 32'h0000_3D3C;
        tick();
        store_tx_data = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        store_tx_data = 2'b00;
        tx_data = '0;
        get_rx_data = 2'b00;
        clear_data_buffer = 1'b0;
        rx_byte_valid = 1'b0;
        rx_byte = '0;
        tx_byte_req = 1'b0;
        tick();
        tick();
        chk("rst_occ", {24'h0, buffer_occupancy}, 32'd0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        chk("rst_pulses", {29'h0, overflow, underflow, dir_error}, 32'h0);
        chk("rst_stall", {31'h0, ahb_stall}, 32'h0);
        rst = 1'b0;
        tick();

        // AHB store 4 bytes, USB TX pops them; first pop contends with an AHB get
        store_tx_data = 2'b11;
        tx_data = 32'h4433_2211;
        #1 chk("t1_store_nostall", {31'h0, ahb_stall}, 32'h0);
        tick();
        store_tx_data = 2'b00;
        chk("t1_occ4", {24'h0, buffer_occupancy}, 32'd4);
        tx_byte_req = 1'b1;
        get_rx_data = 2'b01;
        #1 chk("t1_rd_stall", {31'h0, ahb_stall}, 32'h1);
        tick();
        get_rx_data = 2'b00;
        chk("t1_tx0", {24'h0, tx_byte}, 32'h11);
        chk("t1_rx_held", rx_data, 32'h0);
        chk("t1_occ3", {24'h0, buffer_occupancy}, 32'd3);
        tick();
        chk("t1_tx1", {24'h0, tx_byte}, 32'h22);
        tick();
        chk("t1_tx2", {24'h0, tx_byte}, 32'h33);
        tick();
        tx_byte_req = 1'b0;
        chk("t1_tx3", {24'h0, tx_byte}, 32'h44);
        chk("t1_occ0", {24'h0, buffer_occupancy}, 32'd0);

        // USB RX pushes AA..AE, AHB reads a word then a byte (mode back in IDLE accepts RX)
        for (int i = 0; i < 5; i++) begin
            rx_byte_valid = 1'b1;
            rx_byte = 8'hAA + 8'(i);
            tick();
        end
        rx_byte_valid = 1'b0;
        chk("t2_occ5", {24'h0, buffer_occupancy}, 32'd5);
        chk("t2_no_dir_err", {31'h0, dir_error}, 32'h0);
        get_rx_data = 2'b11;
        tick();
        chk("t2_word", rx_data, 32'hADAC_ABAA);
        chk("t2_no_udf", {31'h0, underflow}, 32'h0);
        get_rx_data = 2'b01;
        tick();
        get_rx_data = 2'b00;
        chk("t2_byte", rx_data, 32'h0000_00AE);
        chk("t2_occ0", {24'h0, buffer_occupancy}, 32'd0);

        // Same-cycle AHB store and USB RX push in IDLE: RX wins, store later dropped
        store_tx_data = 2'b01;
        tx_data = 32'h0000_0055;
        rx_byte_valid = 1'b1;
        rx_byte = 8'h77;
        #1 chk("t3_wr_stall", {31'h0, ahb_stall}, 32'h1);
        tick();
        rx_byte_valid = 1'b0;
        chk("t3_occ1", {24'h0, buffer_occupancy}, 32'd1);
        #1 chk("t3_drop_nostall", {31'h0, ahb_stall}, 32'h0);
        tick();
        store_tx_data = 2'b00;
        chk("t3_dir_err", {31'h0, dir_error}, 32'h1);
        chk("t3_occ_still1", {24'h0, buffer_occupancy}, 32'd1);
        tick();
        chk("t3_dir_err_pulse", {31'h0, dir_error}, 32'h0);
        tx_byte_req = 1'b1;
        tick();
        tx_byte_req = 1'b0;
        chk("t3_tx77", {24'h0, tx_byte}, 32'h77);

        // Short read: 3 bytes present, 4 requested
        for (int i = 0; i < 3; i++) begin
            rx_byte_valid = 1'b1;
            rx_byte = 8'h01 + 8'(i);
            tick();
        end
        rx_byte_valid = 1'b0;
        chk("t4_occ3", {24'h0, buffer_occupancy}, 32'd3);
        get_rx_data = 2'b11;
        tick();
        get_rx_data = 2'b00;
        chk("t4_short_word", rx_data, 32'h0003_0201);
        chk("t4_udf", {31'h0, underflow}, 32'h1);
        chk("t4_occ0", {24'h0, buffer_occupancy}, 32'd0);
        get_rx_data = 2'b01;
        tick();
        get_rx_data = 2'b00;
        chk("t4_empty_read", rx_data, 32'h0);
        chk("t4_empty_udf", {31'h0, underflow}, 32'h1);

        // Clear mid RX fill while an AHB store is also requested
        for (int i = 0; i < 2; i++) begin
            rx_byte_valid = 1'b1;
            rx_byte = 8'h10 + 8'(i);
            tick();
        end
        rx_byte_valid = 1'b0;
        chk("t4_occ2", {24'h0, buffer_occupancy}, 32'd2);
        clear_data_buffer = 1'b1;
        store_tx_data = 2'b11;
        #1 chk("t4_clear_nostall", {31'h0, ahb_stall}, 32'h0);
        tick();
        clear_data_buffer = 1'b0;
        store_tx_data = 2'b00;
        chk("t4_clear_occ", {24'h0, buffer_occupancy}, 32'd0);
        chk("t4_clear_pulses", {29'h0, overflow, underflow, dir_error}, 32'h0);

        // Fill to 62 from address 0, then a 4-byte store must be rejected
        fill62();
        chk("t5_occ62", {24'h0, buffer_occupancy}, 32'd62);
        store_tx_data = 2'b11;
        tx_data = 32'hFFFF_FFFF;
        #1 chk("t5_ovf_nostall", {31'h0, ahb_stall}, 32'h0);
        tick();
        store_tx_data = 2'b00;
        chk("t5_ovf", {31'h0, overflow}, 32'h1);
        chk("t5_ovf_occ", {24'h0, buffer_occupancy}, 32'd62);
        tick();
        chk("t5_ovf_pulse", {31'h0, overflow}, 32'h0);

        // Drain the 62 bytes, checking first and last words
        get_rx_data = 2'b11;
        tick();
        chk("t5_first_word", rx_data, 32'h0302_0100);
        chk("t5_occ58", {24'h0, buffer_occupancy}, 32'd58);
        for (int k = 0; k < 14; k++) tick();
        get_rx_data = 2'b10;
        tick();
        get_rx_data = 2'b00;
        chk("t5_last_half", rx_data, 32'h0000_3D3C);
        chk("t5_drained", {24'h0, buffer_occupancy}, 32'd0);

        // Pointers now at 62: 4-byte store wraps to 62,63,0,1
        store_tx_data = 2'b11;
        tx_data = 32'hDDCC_BBAA;
        tick();
        store_tx_data = 2'b00;
        chk("t6_occ4", {24'h0, buffer_occupancy}, 32'd4);
        get_rx_data = 2'b10;
        tick();
        chk("t6_wrap_lo", rx_data, 32'h0000_BBAA);
        tick();
        get_rx_data = 2'b00;
        chk("t6_wrap_hi", rx_data, 32'h0000_DDCC);
        chk("t6_occ0", {24'h0, buffer_occupancy}, 32'd0);

        // Exactly-fits store reaches full; further writes are rejected
        fill62();
        chk("t7_occ62", {24'h0, buffer_occupancy}, 32'd62);
        store_tx_data = 2'b10;
        tx_data = 32'h0000_BEEF;
        tick();
        chk("t7_full", {24'h0, buffer_occupancy}, 32'd64);
        chk("t7_fit_no_ovf", {31'h0, overflow}, 32'h0);
        store_tx_data = 2'b01;
        tick();
        store_tx_data = 2'b00;
        chk("t7_full_ovf", {31'h0, overflow}, 32'h1);
        rx_byte_valid = 1'b1;
        rx_byte = 8'h5A;
        tick();
        rx_byte_valid = 1'b0;
        chk("t7_rx_dir_err", {31'h0, dir_error}, 32'h1);
        chk("t7_rx_no_ovf", {31'h0, overflow}, 32'h0);
        chk("t7_occ64", {24'h0, buffer_occupancy}, 32'd64);
        clear_data_buffer = 1'b1;
        tick();
        clear_data_buffer = 1'b0;
        chk("t7_clear_occ", {24'h0, buffer_occupancy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
